// File: rtl/rs_alu_issue.sv
// rs_alu_issue: reservation station for the ALU pipe.
// Holds renamed ALU ops until both source tags are ready. Captures CDB
// wakeups and issues one op per cycle through a registered issued/data_out
// port. Entries in the mispredict squash window are dropped.
// Optional build macro RS_ALU_AGE_SELECT_EN: when defined, select picks the
// oldest ready entry. When undefined, select picks the lowest-index ready
// entry and no age state exists.

package rs_alu_pkg;
  localparam int RS_PREG_W = 7;

  typedef struct packed {
    logic [RS_PREG_W-1:0] ps1;
    logic [RS_PREG_W-1:0] ps2;
    logic                 ps1_ready;
    logic                 ps2_ready;
    logic [RS_PREG_W-1:0] pd;
    logic [4:0]           rob_index;
    logic [6:0]           Opcode;
    logic [2:0]           func3;
    logic [6:0]           func7;
    logic [31:0]          imm;
  } rs_data;
endpackage

module rs_alu_issue
  import rs_alu_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PREG_W = RS_PREG_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dispatch_valid,
  input  rs_data                 dispatch_data,
  output logic                   rs_full,
  input  logic [1:0]             cdb_valid,
  input  logic [1:0][PREG_W-1:0] cdb_tag,
  input  logic                   fu_alu_ready,
  output logic                   issued,
  output rs_data                 data_out,
  input  logic [4:0]             curr_rob_tag,
  input  logic                   mispredict,
  input  logic [4:0]             mispredict_tag
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] valid_q, rdy1_q, rdy2_q;
  rs_data           data_q [DEPTH];

  logic [DEPTH-1:0] rdy1_now, rdy2_now, cand, squash, removed;
  logic [IDX_W-1:0] free_idx, sel_idx;
  logic             sel_found, do_dispatch, do_issue, disp_rdy1, disp_rdy2;
  logic [3:0]       squash_start, squash_span;
  rs_data           issue_data;

  // ROB tags only use their low four bits for window arithmetic.
  logic unused_tag_msbs;
  assign unused_tag_msbs = ^{curr_rob_tag[4], mispredict_tag[4]};

  function automatic logic cdb_hit(input logic [1:0]             v,
                                   input logic [1:0][PREG_W-1:0] tags,
                                   input logic [PREG_W-1:0]      tag);
    return (v[0] && (tags[0] == tag)) || (v[1] && (tags[1] == tag));
  endfunction

  assign rs_full     = &valid_q;
  assign do_dispatch = dispatch_valid && !rs_full && !mispredict;
  assign do_issue    = fu_alu_ready && !mispredict && sel_found;
  assign disp_rdy1   = dispatch_data.ps1_ready || cdb_hit(cdb_valid, cdb_tag, dispatch_data.ps1);
  assign disp_rdy2   = dispatch_data.ps2_ready || cdb_hit(cdb_valid, cdb_tag, dispatch_data.ps2);

  // Live readiness (stored bits plus this cycle's CDB), squash window and free slot.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    rdy1_now     = '0;
    rdy2_now     = '0;
    cand         = '0;
    squash       = '0;
    free_idx     = '0;
    squash_start = mispredict_tag[3:0] + 4'd1;
    squash_span  = curr_rob_tag[3:0] - squash_start;
    for (int i = 0; i < DEPTH; i++) begin
      rdy1_now[i] = rdy1_q[i] || cdb_hit(cdb_valid, cdb_tag, data_q[i].ps1);
      rdy2_now[i] = rdy2_q[i] || cdb_hit(cdb_valid, cdb_tag, data_q[i].ps2);
      cand[i]     = valid_q[i] && rdy1_now[i] && rdy2_now[i];
      // Offset from the first squashed tag, modulo 16, must fall inside the span.
      squash[i]   = mispredict && (4'(data_q[i].rob_index[3:0] - squash_start) < squash_span);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

`ifdef RS_ALU_AGE_SELECT_EN
  logic [IDX_W-1:0] age_q    [DEPTH];
  logic [IDX_W-1:0] age_next [DEPTH];
  logic [IDX_W-1:0] new_age, best_age;

  // Oldest-ready select: ages are dense, 0 is the oldest valid entry.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    best_age  = '1;
    for (int i = 0; i < DEPTH; i++) begin
      if (cand[i] && (!sel_found || (age_q[i] < best_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        best_age  = age_q[i];
      end
    end
  end

  // Close the gaps left by removed entries; a new op gets the survivor count.
  always_comb begin
    new_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_next[i] = age_q[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (removed[j] && (age_q[j] < age_q[i])) age_next[i] = age_next[i] - IDX_W'(1);
      end
      if (valid_q[i] && !removed[i]) new_age = new_age + IDX_W'(1);
    end
  end

  // Age storage; only meaningful while the entry is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) age_q[i] <= age_next[i];
    if (do_dispatch) age_q[free_idx] <= new_age;
  end
`else
  // Lowest-index ready select.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end
`endif

  // Entries leaving this cycle, by issue or by squash.
  always_comb begin
    removed = '0;
    for (int i = 0; i < DEPTH; i++) begin
      removed[i] = valid_q[i] && (squash[i] || (do_issue && (sel_idx == IDX_W'(i))));
    end
  end

  // The issued op carries its live ready state, which is set by construction.
  always_comb begin
    issue_data           = data_q[sel_idx];
    issue_data.ps1_ready = rdy1_now[sel_idx];
    issue_data.ps2_ready = rdy2_now[sel_idx];
  end

  // Occupancy and the registered issue port; reset dominates everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      issued   <= 1'b0;
      data_out <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (removed[i]) valid_q[i] <= 1'b0;
      end
      if (do_dispatch) valid_q[free_idx] <= 1'b1;
      issued <= do_issue;
      if (do_issue) data_out <= issue_data;
    end
  end

  // Entry payload and ready bits.
  always_ff @(posedge clk) begin
    // NOTE: the payload array is not reset; valid_q gates every use, so clearing it buys nothing.
    rdy1_q <= rdy1_now;
    rdy2_q <= rdy2_now;
    if (do_dispatch) begin
      data_q[free_idx] <= dispatch_data;
      rdy1_q[free_idx] <= disp_rdy1;
      rdy2_q[free_idx] <= disp_rdy2;
    end
  end

endmodule

// File: tb/tb_rs_alu_issue.sv
// Self-checking bench for rs_alu_issue: directed stimulus with literal
// expectations, plus a slot/queue model compared against the DUT every cycle.
module tb_rs_alu_issue;
  import rs_alu_pkg::*;

  localparam int DEPTH  = 8;
  localparam int PREG_W = 7;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   dispatch_valid;
  rs_data                 dispatch_data;
  logic                   rs_full;
  logic [1:0]             cdb_valid;
  logic [1:0][PREG_W-1:0] cdb_tag;
  logic                   fu_alu_ready;
  logic                   issued;
  rs_data                 data_out;
  logic [4:0]             curr_rob_tag;
  logic                   mispredict;
  logic [4:0]             mispredict_tag;

  always #5 clk = ~clk;

  rs_alu_issue #(.DEPTH(DEPTH), .PREG_W(PREG_W)) dut (
    .clk(clk), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_data(dispatch_data), .rs_full(rs_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .fu_alu_ready(fu_alu_ready),
    .issued(issued), .data_out(data_out),
    .curr_rob_tag(curr_rob_tag), .mispredict(mispredict), .mispredict_tag(mispredict_tag)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rs_data strip(input rs_data d);
    rs_data r;
    r = d;
    r.ps1_ready = 1'b0;
    r.ps2_ready = 1'b0;
    return r;
  endfunction

  function automatic rs_data mk(input int rob, input int p1, input bit r1, input int p2, input bit r2);
    rs_data d;
    d           = '0;
    d.ps1       = 7'(p1);
    d.ps2       = 7'(p2);
    d.ps1_ready = r1;
    d.ps2_ready = r2;
    d.pd        = 7'(64 + rob);
    d.rob_index = 5'(rob);
    d.Opcode    = 7'h13;
    d.func3     = 3'(rob % 8);
    d.func7     = 7'(rob);
    d.imm       = 32'(rob * 4 + 1);
    return d;
  endfunction

  // ---------------- behavioural model ----------------
  bit     m_valid [DEPTH];
  bit     m_r1    [DEPTH];
  bit     m_r2    [DEPTH];
  rs_data m_op    [DEPTH];
  int     m_seq   [DEPTH];
  int     seq_ctr = 0;
  bit     m_issued;
  rs_data m_out;

  function automatic bit hit(input logic [PREG_W-1:0] tag);
    return (cdb_valid[0] && cdb_tag[0] == tag) || (cdb_valid[1] && cdb_tag[1] == tag);
  endfunction

  always @(posedge clk) begin : model_step
    bit         full;
    int         sel;
    int         free;
    bit         in_win [16];
    logic [3:0] t;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      m_issued = 1'b0;
      m_out    = '0;
    end else begin
      full = 1'b1;
      free = -1;
      for (int i = 0; i < DEPTH; i++) begin
        if (!m_valid[i]) begin
          full = 1'b0;
          if (free < 0) free = i;
        end
      end
      sel = -1;
      if (fu_alu_ready && !mispredict) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (m_valid[i] && (m_r1[i] || hit(m_op[i].ps1)) && (m_r2[i] || hit(m_op[i].ps2))) begin
`ifdef RS_ALU_AGE_SELECT_EN
            if (sel < 0 || m_seq[i] < m_seq[sel]) sel = i;
`else
            if (sel < 0) sel = i;
`endif
          end
        end
      end
      m_issued = (sel >= 0);
      if (sel >= 0) m_out = m_op[sel];
      for (int i = 0; i < DEPTH; i++) begin
        if (m_valid[i]) begin
          m_r1[i] = m_r1[i] || hit(m_op[i].ps1);
          m_r2[i] = m_r2[i] || hit(m_op[i].ps2);
        end
      end
      for (int k = 0; k < 16; k++) in_win[k] = 1'b0;
      if (mispredict) begin
        t = mispredict_tag[3:0] + 4'd1;
        for (int k = 0; k < 16; k++) begin
          if (t == curr_rob_tag[3:0]) break;
          in_win[t] = 1'b1;
          t = t + 4'd1;
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (m_valid[i] && in_win[m_op[i].rob_index[3:0]]) m_valid[i] = 1'b0;
      end
      if (sel >= 0) m_valid[sel] = 1'b0;
      if (dispatch_valid && !full && !mispredict) begin
        m_valid[free] = 1'b1;
        m_op[free]    = dispatch_data;
        m_r1[free]    = dispatch_data.ps1_ready || hit(dispatch_data.ps1);
        m_r2[free]    = dispatch_data.ps2_ready || hit(dispatch_data.ps2);
        m_seq[free]   = seq_ctr;
        seq_ctr++;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin : compare
    bit mf;
    mf = 1'b1;
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) mf = 1'b0;
    check("model issued", 128'(issued), 128'(m_issued));
    check("model rs_full", 128'(rs_full), 128'(mf));
    if (m_issued) check("model data_out", 128'(strip(data_out)), 128'(strip(m_out)));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic disp(input rs_data d);
    dispatch_valid = 1'b1;
    dispatch_data  = d;
    tick();
    dispatch_valid = 1'b0;
  endtask

  task automatic cdb(input logic [1:0] v, input int t0, input int t1);
    cdb_valid  = v;
    cdb_tag[0] = 7'(t0);
    cdb_tag[1] = 7'(t1);
  endtask

  task automatic expect_issue(input string name, input int rob);
    check({name, " issued"}, 128'(issued), 128'(1));
    check({name, " rob"}, 128'(data_out.rob_index), 128'(rob));
  endtask

  initial begin
    reset          = 1'b1;
    dispatch_valid = 1'b0;
    dispatch_data  = '0;
    cdb_valid      = '0;
    cdb_tag        = '0;
    fu_alu_ready   = 1'b1;
    curr_rob_tag   = '0;
    mispredict     = 1'b0;
    mispredict_tag = '0;
    tick();
    tick();
    check("reset issued", 128'(issued), 128'(0));
    check("reset rs_full", 128'(rs_full), 128'(0));
    check("reset data_out", 128'(data_out), 128'(0));
    reset = 1'b0;

    // Ready ADDI: one cycle dispatch-to-issue, no earlier.
    disp(mk(3, 1, 1, 2, 1));
    check("t1 not yet", 128'(issued), 128'(0));
    tick();
    expect_issue("t1", 3);
    check("t1 rs_full", 128'(rs_full), 128'(0));
    tick();
    check("t1 pulse", 128'(issued), 128'(0));

    // Waiting on ps1=12; issue the cycle after the broadcast.
    disp(mk(4, 12, 0, 5, 1));
    tick();
    tick();
    check("t2 waiting", 128'(issued), 128'(0));
    cdb(2'b01, 12, 0);
    tick();
    cdb(2'b00, 0, 0);
    expect_issue("t2 wake", 4);
    tick();
    check("t2 pulse", 128'(issued), 128'(0));

    // Wakeup on both CDB lanes in the dispatch cycle itself.
    cdb(2'b11, 30, 31);
    disp(mk(5, 30, 0, 31, 0));
    cdb(2'b00, 0, 0);
    check("t2b not yet", 128'(issued), 128'(0));
    tick();
    expect_issue("t2b", 5);

    // Fill, drop a dispatch while full, then drain.
    for (int i = 0; i < DEPTH; i++) disp(mk(i, 20 + i, 0, 2, 1));
    check("t3 full", 128'(rs_full), 128'(1));
    dispatch_valid = 1'b1;
    dispatch_data  = mk(8, 40, 1, 41, 1);
    tick();
    tick();
    dispatch_valid = 1'b0;
    check("t3 still full", 128'(rs_full), 128'(1));
    check("t3 dropped", 128'(issued), 128'(0));
    cdb(2'b01, 20, 0);
    tick();
    expect_issue("t3 slot0", 0);
    check("t3 not full", 128'(rs_full), 128'(0));
    for (int k = 1; k < DEPTH; k++) begin
      cdb(2'b10, 0, 20 + k);
      tick();
      expect_issue("t3 drain", k);
    end
    cdb(2'b00, 0, 0);
    tick();
    check("t3 empty", 128'(issued), 128'(0));

    // Wrapping squash window 15..1; the branch (14) survives.
    disp(mk(14, 50, 0, 2, 1));
    disp(mk(15, 51, 0, 2, 1));
    disp(mk(0, 52, 0, 2, 1));
    disp(mk(1, 53, 0, 2, 1));
    mispredict     = 1'b1;
    mispredict_tag = 5'd14;
    curr_rob_tag   = 5'd2;
    cdb(2'b01, 50, 0);
    tick();
    mispredict = 1'b0;
    cdb(2'b00, 0, 0);
    check("t4 flush cycle", 128'(issued), 128'(0));
    tick();
    expect_issue("t4 kept", 14);
    cdb(2'b11, 51, 52);
    tick();
    check("t4 squashed a", 128'(issued), 128'(0));
    cdb(2'b01, 53, 0);
    tick();
    check("t4 squashed b", 128'(issued), 128'(0));
    cdb(2'b00, 0, 0);
    tick();
    check("t4 squashed c", 128'(issued), 128'(0));
    check("t4 rs_full", 128'(rs_full), 128'(0));

    // Empty window: tag+1 == tail clears nothing.
    disp(mk(5, 54, 0, 2, 1));
    mispredict     = 1'b1;
    mispredict_tag = 5'd4;
    curr_rob_tag   = 5'd5;
    tick();
    mispredict = 1'b0;
    cdb(2'b01, 54, 0);
    tick();
    cdb(2'b00, 0, 0);
    expect_issue("t4 empty window", 5);

    // Back-pressure holds ready entries, then two back-to-back issues.
    fu_alu_ready = 1'b0;
    disp(mk(6, 1, 1, 2, 1));
    disp(mk(7, 3, 1, 4, 1));
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t5 held", 128'(issued), 128'(0));
    end
    fu_alu_ready = 1'b1;
    tick();
    expect_issue("t5 first", 6);
    tick();
    expect_issue("t5 second", 7);
    tick();
    check("t5 idle", 128'(issued), 128'(0));

    // A(slot0, waiting) and B(slot1, ready); flush A; C refills slot0.
    fu_alu_ready = 1'b0;
    disp(mk(8, 60, 0, 2, 1));
    disp(mk(9, 3, 1, 4, 1));
    mispredict     = 1'b1;
    mispredict_tag = 5'd7;
    curr_rob_tag   = 5'd9;
    tick();
    mispredict = 1'b0;
    disp(mk(10, 5, 1, 6, 1));
    fu_alu_ready = 1'b1;
    tick();
`ifdef RS_ALU_AGE_SELECT_EN
    expect_issue("t6 oldest", 9);
    tick();
    expect_issue("t6 younger", 10);
`else
    expect_issue("t6 low index", 10);
    tick();
    expect_issue("t6 high index", 9);
`endif
    tick();
    check("t6 idle", 128'(issued), 128'(0));

    // Reset mid-operation drops the pending entry and the concurrent dispatch.
    disp(mk(12, 70, 0, 2, 1));
    reset          = 1'b1;
    dispatch_valid = 1'b1;
    dispatch_data  = mk(11, 1, 1, 2, 1);
    tick();
    reset          = 1'b0;
    dispatch_valid = 1'b0;
    check("t7 reset issued", 128'(issued), 128'(0));
    check("t7 reset rs_full", 128'(rs_full), 128'(0));
    cdb(2'b01, 70, 0);
    tick();
    cdb(2'b00, 0, 0);
    check("t7 no dispatch", 128'(issued), 128'(0));
    tick();
    check("t7 no stale", 128'(issued), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
